serial_word_receiver: RTL and testbench
=======================================

# serial_word_receiver

- Serial-to-parallel receiver for the serial stream produced by the 4-bit shift-register family.
- Samples `S_IN` on each `ENB` strobe and frames words as: start bit (0), `WIDTH` data bits, stop bit (1).
- Honours the transmitter's shift direction (`DIR`) and assembles each word in a holding register.
- Presents words on `Q` through a valid/ready handshake, with framing-error and overrun reporting.

## Interface
- `WIDTH`, 4, number of data bits per frame (≥2).
- `CLK` input 1: single clock; all state updates on rising edge.
- `RESET` input 1: synchronous, active-high reset.
- `ENB` input 1: bit strobe; `S_IN` and `DIR` are sampled only on edges where `ENB`=1.
- `S_IN` input 1: serial line; idles high.
- `DIR` input 1: bit order, captured with the start bit. 0 = first data bit goes to `Q[0]` (LSB first); 1 = first data bit goes to `Q[WIDTH-1]` (MSB first).
- `Q_READY` input 1: consumer accepts `Q` on an edge where `Q_VALID`&`Q_READY`.
- `Q` output `WIDTH`: last completed word.
- `Q_VALID` output 1: `Q` holds an unconsumed word.
- `BUSY` output 1: a frame is in progress (state ≠ IDLE).
- `ERR` output 1: one-cycle pulse on framing error.
- `OVERRUN` output 1: one-cycle pulse when a completed word is dropped.

## Operation
- States: IDLE, DATA, STOP, RESYNC.
- IDLE:
  - `ENB`&`S_IN`=0 → DATA; latch `DIR`; clear the bit counter.
  - Otherwise remain in IDLE.
- DATA:
  - On each `ENB`, shift `S_IN` into the shift register. DIR=0 shifts right, inserting at the MSB; DIR=1 shifts left, inserting at the LSB. Either way the first bit ends at the position given under `DIR`.
  - Increment the counter. After the `WIDTH`-th data bit → STOP.
  - The counter is ⌈log2(WIDTH)⌉ bits wide and never wraps past `WIDTH`-1.
- STOP, on `ENB`:
  - `S_IN`=1: the word completes. → IDLE.
  - `S_IN`=0: framing error. `ERR` pulses, the word is discarded, `Q`/`Q_VALID` are unchanged. → RESYNC.
- RESYNC:
  - `ENB`&`S_IN`=1 → IDLE. Otherwise stay in RESYNC.
  - A line held low after an error is never taken as a start bit.
- Word completion, with `Q_VALID`=0, or `Q_VALID`=1 with `Q_READY`=1 in the same cycle: `Q` ← the assembled word, `Q_VALID` ← 1. This is a simultaneous consume-and-refill, with no overrun.
- Word completion with `Q_VALID`=1 and `Q_READY`=0: the new word is dropped, `Q` is kept, `OVERRUN` pulses.
- Consume without completion: `Q_VALID` ← 0. `Q` holds its value.
- `DIR` changes mid-frame are ignored; the latched value governs the whole frame.
- `ENB`=0 cycles freeze the FSM, the counter and the shift register. The handshake still operates.

## Timing
- Reset values: `Q`=0, `Q_VALID`=0, `BUSY`=0, `ERR`=0, `OVERRUN`=0, state=IDLE, counter=0, shift register=0.
- `RESET` mid-frame aborts the frame with no `ERR`.
- `RESET` has priority over all other inputs.
- Latency: `Q_VALID` rises on the edge that samples a valid stop bit, i.e. visible the cycle after that `ENB` cycle.
- `ERR` and `OVERRUN` are registered and high for exactly one cycle, the cycle after the offending stop-bit sample.
- `BUSY` rises the cycle after the start-bit sample. It falls the cycle after the stop-bit sample, or after the RESYNC exit.
- Minimum frame: `WIDTH`+2 `ENB` strobes.
- Back-to-back frames: a start bit may be sampled on the `ENB` immediately after the stop bit.
- The handshake is independent of `ENB` and completes in one cycle.

## Test plan
- Reset then idle: hold `S_IN`=1 with `ENB`=1 for 10 cycles → all outputs 0, `BUSY`=0.
- LSB-first frame, `DIR`=0: bits 0,1,0,1,1,1 (start, d0..d3=1,0,1,1, stop) with `Q_READY`=0 → `Q`=4'b1101, `Q_VALID`=1 one cycle after the stop sample, held until `Q_READY`=1, then `Q_VALID`=0.
- MSB-first frame, `DIR`=1: same bit stream, `ENB` strobing every 3rd cycle, and `DIR` toggled mid-frame → `Q`=4'b1011.
- Framing error: 0,1,1,1,1,0 then `S_IN` held low for 4 strobes → `ERR` pulses once, `Q_VALID` stays 0, no new frame starts. Then `S_IN`=1 followed by a valid frame 0xA → `Q`=4'hA.
- Overrun and simultaneous consume: frame 0x3 unread, then frame 0x5 with `Q_READY`=0 → `OVERRUN` pulse, `Q`=4'h3. Then frame 0x9 completing with `Q_READY`=1 on the same edge → `Q`=4'h9, `Q_VALID`=1, no `OVERRUN`.
- Reset mid-frame: assert `RESET` after 2 data bits → `BUSY`=0 next cycle, no `ERR`. The next full frame 0xF is received correctly.

Source files
------------

// File: rtl/serial_word_receiver_if.sv
// Handshake/bus bundle for serial_word_receiver.
//   enb      : bit strobe; s_in and dir are sampled only when high
//   s_in     : serial line, idles high
//   dir      : bit order of the frame, captured with the start bit
//   q_ready  : consumer accepts q when q_valid & q_ready
//   q        : last completed word
//   q_valid  : q holds an unconsumed word
//   busy     : frame in progress
//   err      : one-cycle framing-error pulse
//   overrun  : one-cycle pulse when a completed word is dropped
// master = stimulus/consumer side, slave = receiver side.
interface serial_word_receiver_if #(
    parameter int unsigned WIDTH = 4
);
    logic             enb;
    logic             s_in;
    logic             dir;
    logic             q_ready;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             busy;
    logic             err;
    logic             overrun;

    modport master (
        output enb, s_in, dir, q_ready,
        input  q, q_valid, busy, err, overrun
    );

    modport slave (
        input  enb, s_in, dir, q_ready,
        output q, q_valid, busy, err, overrun
    );
endinterface

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver. Frames are: start bit (0), WIDTH data bits, stop bit (1),
// sampled on enb strobes. Completed words are offered on q with a valid/ready handshake.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset, highest priority
//   bus   : serial_word_receiver_if slave modport (see interface header)
module serial_word_receiver #(
    parameter int unsigned WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    serial_word_receiver_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {StIdle, StData, StStop, StResync} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic [WIDTH-1:0] shreg_q;
    logic             dir_q;
    logic [WIDTH-1:0] q_q;
    logic             q_valid_q;
    logic             busy_q;
    logic             err_q;
    logic             overrun_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            shreg_q   <= '0;
            dir_q     <= 1'b0;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            err_q     <= 1'b0;
            overrun_q <= 1'b0;

            // Consume runs independently of enb; a completion below may override it (refill).
            if (q_valid_q && bus.q_ready) begin
                q_valid_q <= 1'b0;
            end

            if (bus.enb) begin
                unique case (state_q)
                    StIdle: begin
                        if (!bus.s_in) begin
                            state_q <= StData;
                            dir_q   <= bus.dir;
                            cnt_q   <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    StData: begin
                        // LSB-first shifts right so the first bit lands in bit 0 after WIDTH
                        // shifts; MSB-first shifts left so it lands in bit WIDTH-1.
                        if (dir_q) begin
                            shreg_q <= {shreg_q[WIDTH-2:0], bus.s_in};
                        end else begin
                            shreg_q <= {bus.s_in, shreg_q[WIDTH-1:1]};
                        end
                        if (cnt_q == CntW'(WIDTH - 1)) begin
                            state_q <= StStop;
                        end else begin
                            cnt_q <= cnt_q + CntW'(1);
                        end
                    end
                    StStop: begin
                        if (bus.s_in) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                            if (!q_valid_q || bus.q_ready) begin
                                q_q       <= shreg_q;
                                q_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            err_q   <= 1'b1;
                            state_q <= StResync;
                        end
                    end
                    StResync: begin
                        // Wait for the line to return high so a stuck-low line is not a start.
                        if (bus.s_in) begin
                            state_q <= StIdle;
                            busy_q  <= 1'b0;
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.busy    = busy_q;
    assign bus.err     = err_q;
    assign bus.overrun = overrun_q;
endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH = 4).
module tb_serial_word_receiver;
    logic clk;
    logic reset;
    int   vectors;
    int   miscompares;

    serial_word_receiver_if #(.WIDTH(4)) bus ();

    serial_word_receiver #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One strobed bit followed by gap idle (enb=0) cycles.
    task automatic send_bit(input logic b, input int gap);
        bus.s_in = b;
        bus.enb  = 1'b1;
        tick();
        bus.enb  = 1'b0;
        for (int i = 0; i < gap; i++) tick();
    endtask

    // Start + data bits in line order for direction d; stop bit left to the caller.
    task automatic send_body(input logic [3:0] data, input logic d);
        bus.dir = d;
        send_bit(1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            send_bit(d ? data[3-i] : data[i], 0);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        bus.enb     = 1'b0;
        bus.s_in    = 1'b1;
        bus.dir     = 1'b0;
        bus.q_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        tick();
        chk("reset_q", bus.q, 4'h0);
        chk("reset_valid", bus.q_valid, 1'b0);
        chk("reset_busy", bus.busy, 1'b0);
        chk("reset_err", bus.err, 1'b0);
        chk("reset_overrun", bus.overrun, 1'b0);

        // Idle line with strobes must not start a frame.
        bus.enb = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        bus.enb = 1'b0;
        chk("idle_busy", bus.busy, 1'b0);
        chk("idle_valid", bus.q_valid, 1'b0);
        chk("idle_err", bus.err, 1'b0);

        // LSB-first: 0,1,0,1,1,1 -> 4'b1101.
        bus.dir = 1'b0;
        send_bit(1'b0, 0);
        chk("lsb_busy_after_start", bus.busy, 1'b1);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        chk("lsb_valid_before_stop", bus.q_valid, 1'b0);
        send_bit(1'b1, 0);
        chk("lsb_valid", bus.q_valid, 1'b1);
        chk("lsb_q", bus.q, 4'b1101);
        chk("lsb_busy_after_stop", bus.busy, 1'b0);
        tick();
        tick();
        chk("lsb_valid_held", bus.q_valid, 1'b1);
        bus.q_ready = 1'b1;
        tick();
        bus.q_ready = 1'b0;
        chk("lsb_consumed", bus.q_valid, 1'b0);
        chk("lsb_q_kept", bus.q, 4'b1101);

        // MSB-first, strobe every 3rd cycle, dir toggled mid-frame -> 4'b1011.
        bus.dir = 1'b1;
        send_bit(1'b0, 2);
        bus.dir = 1'b0;
        send_bit(1'b1, 2);
        send_bit(1'b0, 2);
        bus.dir = 1'b1;
        send_bit(1'b1, 2);
        bus.dir = 1'b0;
        send_bit(1'b1, 2);
        chk("msb_busy_idle_cycles", bus.busy, 1'b1);
        bus.s_in = 1'b1;
        bus.enb  = 1'b1;
        tick();
        bus.enb  = 1'b0;
        chk("msb_valid", bus.q_valid, 1'b1);
        chk("msb_q", bus.q, 4'b1011);
        bus.q_ready = 1'b1;
        tick();
        bus.q_ready = 1'b0;
        chk("msb_consumed", bus.q_valid, 1'b0);

        // Framing error, then line held low: no new frame until it returns high.
        send_body(4'hF, 1'b0);
        send_bit(1'b0, 0);
        chk("ferr_err_pulse", bus.err, 1'b1);
        chk("ferr_valid", bus.q_valid, 1'b0);
        chk("ferr_q_kept", bus.q, 4'b1011);
        for (int i = 0; i < 4; i++) send_bit(1'b0, 0);
        chk("ferr_err_once", bus.err, 1'b0);
        chk("ferr_resync_busy", bus.busy, 1'b1);
        chk("ferr_no_word", bus.q_valid, 1'b0);
        send_bit(1'b1, 0);
        chk("ferr_resync_exit", bus.busy, 1'b0);
        send_body(4'hA, 1'b0);
        send_bit(1'b1, 0);
        chk("ferr_recover_valid", bus.q_valid, 1'b1);
        chk("ferr_recover_q", bus.q, 4'hA);
        bus.q_ready = 1'b1;
        tick();
        bus.q_ready = 1'b0;

        // Overrun, then simultaneous consume-and-refill.
        send_body(4'h3, 1'b0);
        send_bit(1'b1, 0);
        chk("ovr_first_q", bus.q, 4'h3);
        send_body(4'h5, 1'b0);
        send_bit(1'b1, 0);
        chk("ovr_pulse", bus.overrun, 1'b1);
        chk("ovr_q_kept", bus.q, 4'h3);
        chk("ovr_valid", bus.q_valid, 1'b1);
        tick();
        chk("ovr_pulse_once", bus.overrun, 1'b0);
        send_body(4'h9, 1'b0);
        bus.q_ready = 1'b1;
        send_bit(1'b1, 0);
        bus.q_ready = 1'b0;
        chk("refill_q", bus.q, 4'h9);
        chk("refill_valid", bus.q_valid, 1'b1);
        chk("refill_no_overrun", bus.overrun, 1'b0);
        bus.q_ready = 1'b1;
        tick();
        bus.q_ready = 1'b0;
        chk("refill_consumed", bus.q_valid, 1'b0);

        // Reset after two data bits aborts silently; next frame is clean.
        bus.dir = 1'b0;
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_err", bus.err, 1'b0);
        send_body(4'hF, 1'b0);
        send_bit(1'b1, 0);
        chk("rst_next_valid", bus.q_valid, 1'b1);
        chk("rst_next_q", bus.q, 4'hF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
